osd_char_buffer: RTL and testbench
==================================

Name: osd_char_buffer

Overview:
- Character-cell screen buffer at the sink of the OSD write chain.
- Accepts single-cycle character writes from the OSD writers (hex/decimal/string), each one address plus one ASCII byte per cycle.
- Provides a clear-screen engine and a registered read port for the OSD pixel renderer.
- Write side and read side share one clock.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, rows per screen; DEPTH = COLS*ROWS (1200 by default).
- FILL_CHAR, 8'h20, byte written by clear and returned for out-of-range reads.
- CLEAR_ON_RESET, 1, when 1 a full clear starts automatically on the first cycle after reset deassertion.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- wr_we  in  1  write strobe from a writer; no backpressure.
- wr_addr  in  16  linear cell address (row*COLS+col).
- wr_data  in  8  ASCII byte.
- clear_start  in  1  one-cycle pulse; starts a fill of all cells with FILL_CHAR.
- clear_busy  out  1  high while the clear engine runs.
- clear_done  out  1  one-cycle pulse when the last cell has been filled.
- oob_err  out  1  one-cycle pulse when wr_we targets wr_addr >= DEPTH.
- dirty  out  1  sticky flag: buffer changed since the last dirty_clr.
- dirty_clr  in  1  clears dirty.
- rd_en  in  1  read request from the renderer.
- rd_addr  in  16  cell address to read.
- rd_data  out  8  cell contents; valid the cycle after rd_en.
- rd_valid  out  1  registered copy of rd_en.

Behaviour:
- Reset values:
  - clear_busy=0 (CLEAR_ON_RESET=0) or 1 from the first post-reset edge (CLEAR_ON_RESET=1).
  - clear_done=0, oob_err=0, dirty=0, rd_data=8'h00, rd_valid=0.
  - Internal clear counter = 0. RAM contents are not reset.
- Clear FSM, states IDLE and FILL:
  - IDLE -> FILL on clear_start, or on the first post-reset cycle when CLEAR_ON_RESET=1. Counter loads 0 and clear_busy rises.
  - In FILL, each cycle with wr_we=0 writes FILL_CHAR at the counter address, then increments the counter.
  - When the cell DEPTH-1 is written: FILL -> IDLE, clear_busy falls, clear_done pulses on the next cycle, and dirty is set.
- Write arbitration:
  - Writer writes always win. In any cycle with wr_we=1 and wr_addr<DEPTH, the writer byte is stored.
  - If clear is in FILL that cycle, the clear counter holds; no writer byte is ever dropped.
  - Consequence: a fill of DEPTH cells takes DEPTH plus the number of in-range writer writes accepted during FILL.
  - Writes during FILL to cells the counter has not yet reached are later overwritten. Upstream sequencers must wait for clear_done before issuing content writes.
- Out of range:
  - wr_we with wr_addr>=DEPTH does not write RAM.
  - oob_err pulses on the next cycle; dirty is unchanged and the clear counter still advances that cycle.
- clear_start while in FILL restarts the counter at 0; no clear_done is emitted for the aborted pass.
- dirty:
  - Set on any in-range writer write and on clear completion; cleared by dirty_clr.
  - Simultaneous set and dirty_clr: set wins, dirty=1.
- Read port:
  - rd_en at cycle N gives rd_valid=1 and rd_data at N+1.
  - rd_data=RAM[rd_addr] if rd_addr<DEPTH, otherwise FILL_CHAR.
  - Read of an address written in the same cycle returns the old data (read-before-write).
  - rd_data holds its value when rd_en=0.
- Reset mid-clear: everything returns to reset values. With CLEAR_ON_RESET=1 the clear restarts from 0 after release.

Decomposition:
- osd_format_pkg gains:
  - Constants: OSD_COLS, OSD_ROWS, OSD_DEPTH, OSD_FILL_CHAR.
  - Function osd_cell_addr(row,col) returning the linear address (row*OSD_COLS+col).
  - Typedef osd_clr_state_t {IDLE, FILL}.
- One sub-module: osd_dpram, a simple dual-port RAM with one write port, one registered read port, read-before-write, and no reset. It is sized DEPTH x 8.

Test Plan:
- Reset with CLEAR_ON_RESET=1, no other stimulus -> clear_busy high for exactly 1200 cycles, clear_done pulses once, dirty=1; reads of 0, 599 and 1199 return 8'h20.
- After clear, write 0x41 to address 85 (row 2, col 5); dirty_clr; read 85 -> rd_valid and rd_data=0x41 one cycle after rd_en; read 1200 -> 8'h20.
- During FILL, assert wr_we for 10 cycles at addresses 0..9 with data 0x30..0x39 -> clear takes 1210 cycles, no byte lost; cells 0..9 hold 0x30..0x39 because the counter has passed them.
- wr_we to 1200 and 0xFFFF -> oob_err pulses once per write, RAM unchanged, dirty unchanged.
- clear_start at counter=500 -> counter restarts at 0, total busy = 500 + 1200 cycles, exactly one clear_done.
- dirty_clr asserted in the same cycle as an in-range write -> dirty=1 afterwards; dirty_clr alone -> dirty=0.

Source files
------------

// File: rtl/osd_format_pkg.sv
// rtl/osd_format_pkg.sv - shared OSD screen geometry, fill byte and clear-engine state type
package osd_format_pkg;

  localparam int         OSD_COLS      = 40;
  localparam int         OSD_ROWS      = 30;
  localparam int         OSD_DEPTH     = OSD_COLS * OSD_ROWS;
  localparam logic [7:0] OSD_FILL_CHAR = 8'h20;

  typedef enum logic {
    IDLE,
    FILL
  } osd_clr_state_t;

  function automatic logic [15:0] osd_cell_addr(input logic [15:0] row, input logic [15:0] col);
    return 16'(32'(row) * OSD_COLS + 32'(col));
  endfunction

endpackage

// File: rtl/osd_dpram.sv
// rtl/osd_dpram.sv - DEPTH x 8 simple dual-port RAM, registered read-before-write read port, no reset
module osd_dpram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/osd_char_buffer.sv
// rtl/osd_char_buffer.sv - OSD character-cell screen buffer with clear engine and renderer read port
module osd_char_buffer
  import osd_format_pkg::*;
#(
  parameter int         COLS           = OSD_COLS,
  parameter int         ROWS           = OSD_ROWS,
  parameter logic [7:0] FILL_CHAR      = OSD_FILL_CHAR,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_we,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        oob_err,
  output logic        dirty,
  input  logic        dirty_clr,
  input  logic        rd_en,
  input  logic [15:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid
);

  localparam int             DEPTH   = COLS * ROWS;
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [15:0]    DEPTH_W = 16'(DEPTH);
  localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

  osd_clr_state_t state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d, cnt_eff;
  logic           pend_q;
  logic           done_q, done_d;
  logic           oob_q, dirty_q, dirty_d;
  logic           rd_valid_q, rd_oob_q, rd_seen_q;
  logic           wr_in, rd_in, fill_we;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  logic [7:0]     ram_wdata, ram_rdata;

  // A clear_start during FILL makes the current cycle the first cell of the new pass.
  always_comb begin
    wr_in   = wr_we && (wr_addr < DEPTH_W);
    rd_in   = rd_addr < DEPTH_W;
    cnt_eff = (state_q == FILL && clear_start) ? '0 : cnt_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fill_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start || pend_q) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (wr_in) begin
          cnt_d = cnt_eff;
        end else begin
          fill_we = 1'b1;
          if (cnt_eff == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_eff + AW'(1);
          end
        end
      end
    endcase
    dirty_d = (wr_in || done_d) ? 1'b1 : (dirty_clr ? 1'b0 : dirty_q);
  end

  assign ram_we    = wr_in || fill_we;
  assign ram_waddr = wr_in ? wr_addr[AW-1:0] : cnt_eff;
  assign ram_wdata = wr_in ? wr_data : FILL_CHAR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= CLEAR_ON_RESET;
      done_q     <= 1'b0;
      oob_q      <= 1'b0;
      dirty_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= 1'b0;
      done_q     <= done_d;
      oob_q      <= wr_we && !wr_in;
      dirty_q    <= dirty_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_oob_q  <= !rd_in;
        rd_seen_q <= 1'b1;
      end
    end
  end

  osd_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (rd_en && rd_in),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // The RAM has no reset, so rd_data reads as zero until the first read lands.
  assign rd_data    = !rd_seen_q ? 8'h00 : (rd_oob_q ? FILL_CHAR : ram_rdata);
  assign rd_valid   = rd_valid_q;
  assign clear_busy = (state_q == FILL);
  assign clear_done = done_q;
  assign oob_err    = oob_q;
  assign dirty      = dirty_q;

endmodule

// File: tb/tb_osd_char_buffer.sv
// tb/tb_osd_char_buffer.sv - scoreboard bench for osd_char_buffer
module tb_osd_char_buffer;
  import osd_format_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_we = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        clear_start = 1'b0;
  logic        clear_busy, clear_done, oob_err, dirty;
  logic        dirty_clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int oob_cnt  = 0;
  logic [7:0] exp_q[$];

  osd_char_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_we       (wr_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .oob_err     (oob_err),
    .dirty       (dirty),
    .dirty_clr   (dirty_clr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    rd_en = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
    chk("rd_valid_latency", rd_valid, 1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_we = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_we = 1'b0;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    tick();
    while (clear_busy && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL clear_timeout: busy still 1 after %0d cycles", n);
    end
    tick();
  endtask

  initial begin
    int b0, d0, o0;
    fork
      forever begin
        @(negedge clk);
        if (clear_busy) busy_cnt++;
        if (clear_done) done_cnt++;
        if (oob_err) oob_cnt++;
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: rd_valid with data 0x%0h and no expected entry", rd_data);
          end else begin
            chk("sb_rd_data", rd_data, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 0);

    // auto clear after reset
    b0 = busy_cnt; d0 = done_cnt;
    rst = 1'b0;
    wait_clear();
    chk("por_busy_cycles", busy_cnt - b0, 1200);
    chk("por_done_pulses", done_cnt - d0, 1);
    chk("por_dirty", dirty, 1);
    rd(16'd0, 8'h20);
    rd(16'd599, 8'h20);
    rd(16'd1199, 8'h20);

    // single write, dirty clear, reads incl. out of range and read-before-write
    wr(osd_cell_addr(16'd2, 16'd5), 8'h41);
    chk("wr_dirty", dirty, 1);
    dirty_clr = 1'b1; tick(); dirty_clr = 1'b0;
    chk("dirty_clr_alone", dirty, 0);
    rd(16'd85, 8'h41);
    rd(16'd1200, 8'h20);
    wr_we = 1'b1; wr_addr = 16'd86; wr_data = 8'h42;
    rd(16'd86, 8'h20);
    wr_we = 1'b0;
    rd(16'd86, 8'h42);
    repeat (3) tick();
    chk("rd_hold", rd_data, 8'h42);

    // dirty set beats dirty_clr
    dirty_clr = 1'b1; wr(16'd100, 8'h55); dirty_clr = 1'b0;
    chk("dirty_set_wins", dirty, 1);
    dirty_clr = 1'b1; tick(); dirty_clr = 1'b0;
    chk("dirty_clr_after", dirty, 0);

    // out-of-range writes
    o0 = oob_cnt;
    wr(16'd1200, 8'h99);
    wr(16'hFFFF, 8'h98);
    repeat (2) tick();
    chk("oob_pulses", oob_cnt - o0, 2);
    chk("oob_dirty", dirty, 0);
    rd(16'd176, 8'h20);
    rd(16'd1199, 8'h20);
    rd(16'd100, 8'h55);

    // writes during fill win and stretch the pass
    b0 = busy_cnt; d0 = done_cnt;
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (100) tick();
    for (int i = 0; i < 10; i++) wr(16'(i), 8'(8'h30 + i));
    wait_clear();
    chk("fillwr_busy_cycles", busy_cnt - b0, 1210);
    chk("fillwr_done_pulses", done_cnt - d0, 1);
    for (int i = 0; i < 10; i++) rd(16'(i), 8'(8'h30 + i));
    rd(16'd10, 8'h20);
    rd(16'd85, 8'h20);

    // restart at counter 500
    b0 = busy_cnt; d0 = done_cnt;
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (500) tick();
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    wait_clear();
    chk("restart_busy_cycles", busy_cnt - b0, 1700);
    chk("restart_done_pulses", done_cnt - d0, 1);

    // reset in the middle of a clear
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (300) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", clear_busy, 0);
    chk("midrst_dirty", dirty, 0);
    chk("midrst_rd_data", rd_data, 8'h00);
    tick();
    b0 = busy_cnt; d0 = done_cnt;
    rst = 1'b0;
    wait_clear();
    chk("midrst_busy_cycles", busy_cnt - b0, 1200);
    chk("midrst_done_pulses", done_cnt - d0, 1);
    rd(16'd0, 8'h20);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
